// File: rtl/udp_gmii_frame_tx.sv
// udp_gmii_frame_tx
// Wraps an 8-bit AXI-Stream payload into an Ethernet II / IPv4 / UDP frame
// and drives it onto a GMII transmit interface (tx_en_o / tx_d_o).
// Build option UDP_GMII_FCS_EN: when defined, the CRC-32 FCS is computed and
// appended after the last data/pad byte. When undefined no CRC logic exists
// and the frame goes straight from PAYLOAD/PAD into the inter-frame gap.
module udp_gmii_frame_tx #(
  parameter int GMII_WIDTH      = 8,
  parameter int PAYLOAD_WIDTH   = 11,
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int IFG_CYCLES      = 12
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  input  logic [PAYLOAD_WIDTH-1:0]   payload_bytes_i,
  input  logic [47:0]                fpga_mac_i,
  input  logic [47:0]                host_mac_i,
  input  logic [31:0]                fpga_ip_i,
  input  logic [31:0]                host_ip_i,
  input  logic [15:0]                fpga_port_i,
  input  logic [15:0]                host_port_i,
  output logic                       tx_en_o,
  output logic [GMII_WIDTH-1:0]      tx_d_o,
  output logic                       underrun_o
);

  localparam int MAX_PAYLOAD = 1472;

  typedef enum logic [3:0] {
    IDLE,
    PREAMBLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    PAD,
`ifdef UDP_GMII_FCS_EN
    FCS,
`endif
    IFG
  } state_t;

`ifdef UDP_GMII_FCS_EN
  localparam state_t AFTER_DATA = FCS;
`else
  localparam state_t AFTER_DATA = IFG;
`endif

  // IPv4 header checksum: end-around-carry sum of the ten header words with
  // the checksum word as zero; only total_len and the addresses vary.
  function automatic logic [15:0] ip_csum(input logic [15:0] tot_len,
                                          input logic [31:0] src,
                                          input logic [31:0] dst);
    logic [19:0] s;
    s = 20'h04500 + 20'(tot_len) + 20'h04011 +
        20'(src[31:16]) + 20'(src[15:0]) + 20'(dst[31:16]) + 20'(dst[15:0]);
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    s = {4'd0, s[15:0]} + {16'd0, s[19:16]};
    return ~s[15:0];
  endfunction

`ifdef UDP_GMII_FCS_EN
  // One byte of the reflected Ethernet CRC-32 (poly 0xEDB88320).
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`endif

  state_t                  state_p0, state_n;
  logic [10:0]             cnt_p0, cnt_n;
  logic                    eop_p0, eop_n;
  logic                    tready_p0, tready_n;
  logic                    en_n, ur_n, start, accepted;
  logic [GMII_WIDTH-1:0]   byte_n;
  logic [10:0]             n_start;

  // Frame context latched on the start cycle
  logic [10:0]             n_p0;
  logic [47:0]             fpga_mac_p0, host_mac_p0;
  logic [31:0]             fpga_ip_p0, host_ip_p0;
  logic [15:0]             fpga_port_p0, host_port_p0;
  logic [15:0]             csum_p1;

  logic [15:0]             tot_len, udp_len;
  logic [335:0]            hdr_vec;
  logic [8:0]              hdr_bit;
  logic [7:0]              hdr_byte;

  assign tot_len  = 16'd28 + 16'(n_p0);
  assign udp_len  = 16'd8 + 16'(n_p0);
  // 42 header bytes (Ethernet 14, IPv4 20, UDP 8), first byte in the MSBs;
  // cnt_p0 walks 0..41 across the three header states.
  assign hdr_vec  = {host_mac_p0, fpga_mac_p0, 16'h0800,
                     16'h4500, tot_len, 16'h0000, 16'h0000, 8'h40, 8'h11,
                     csum_p1, fpga_ip_p0, host_ip_p0,
                     fpga_port_p0, host_port_p0, udp_len, 16'h0000};
  assign hdr_bit  = 9'd335 - {cnt_p0[5:0], 3'b000};
  assign hdr_byte = hdr_vec[hdr_bit -: 8];

  assign n_start = (32'(payload_bytes_i) > 32'(MAX_PAYLOAD)) ?
                   11'(MAX_PAYLOAD) : 11'(payload_bytes_i);

`ifdef UDP_GMII_FCS_EN
  logic [31:0] crc_p1;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  assign fcs_word = ~crc_p1;
  assign fcs_byte = fcs_word[{cnt_p0[1:0], 3'b000} +: 8];
`endif

  assign s_axis_tready = tready_p0;

  // Next state and the byte to be registered onto GMII next cycle
  always_comb begin
    state_n  = state_p0;
    cnt_n    = cnt_p0;
    eop_n    = eop_p0;
    byte_n   = '0;
    en_n     = 1'b0;
    ur_n     = 1'b0;
    start    = 1'b0;
    accepted = tready_p0 & s_axis_tvalid;
    case (state_p0)
      IDLE: begin
        if (s_axis_tvalid && (payload_bytes_i != '0)) begin
          start   = 1'b1;
          eop_n   = 1'b0;
          en_n    = 1'b1;
          byte_n  = 8'h55;
          state_n = PREAMBLE;
          cnt_n   = 11'd1;
        end
      end
      PREAMBLE: begin
        en_n = 1'b1;
        if (cnt_p0 == 11'd7) begin
          byte_n  = 8'hD5;
          state_n = ETH_HDR;
          cnt_n   = '0;
        end else begin
          byte_n = 8'h55;
          cnt_n  = cnt_p0 + 11'd1;
        end
      end
      ETH_HDR, IP_HDR, UDP_HDR: begin
        en_n   = 1'b1;
        byte_n = hdr_byte;
        cnt_n  = cnt_p0 + 11'd1;
        if (cnt_p0 == 11'd13) state_n = IP_HDR;
        if (cnt_p0 == 11'd33) state_n = UDP_HDR;
        if (cnt_p0 == 11'd41) begin
          state_n = PAYLOAD;
          cnt_n   = '0;
        end
      end
      PAYLOAD: begin
        en_n   = 1'b1;
        byte_n = accepted ? s_axis_tdata : '0;
        ur_n   = tready_p0 & ~s_axis_tvalid;
        if (accepted && s_axis_tlast) eop_n = 1'b1;
        if (cnt_p0 == n_p0 - 11'd1) begin
          if (n_p0 < 11'd18) begin
            state_n = PAD;
            cnt_n   = cnt_p0 + 11'd1;
          end else begin
            state_n = AFTER_DATA;
            cnt_n   = '0;
          end
        end else begin
          cnt_n = cnt_p0 + 11'd1;
        end
      end
      PAD: begin
        en_n = 1'b1;
        if (cnt_p0 == 11'd17) begin
          state_n = AFTER_DATA;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_p0 + 11'd1;
        end
      end
`ifdef UDP_GMII_FCS_EN
      FCS: begin
        en_n   = 1'b1;
        byte_n = fcs_byte;
        if (cnt_p0 == 11'd3) begin
          state_n = IFG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_p0 + 11'd1;
        end
      end
`endif
      IFG: begin
        if (cnt_p0 >= 11'(IFG_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_p0 + 11'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    tready_n = (state_n == PAYLOAD) && !eop_n;
  end

  // Control state and registered GMII / AXIS outputs
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_p0   <= IDLE;
      cnt_p0     <= '0;
      eop_p0     <= 1'b0;
      tready_p0  <= 1'b0;
      tx_en_o    <= 1'b0;
      tx_d_o     <= '0;
      underrun_o <= 1'b0;
    end else begin
      state_p0   <= state_n;
      cnt_p0     <= cnt_n;
      eop_p0     <= eop_n;
      tready_p0  <= tready_n;
      tx_en_o    <= en_n;
      tx_d_o     <= byte_n;
      underrun_o <= ur_n;
    end
  end

  // Frame context capture, header checksum and running CRC
  always_ff @(posedge clk_i) begin
    if (start) begin
      n_p0         <= n_start;
      fpga_mac_p0  <= fpga_mac_i;
      host_mac_p0  <= host_mac_i;
      fpga_ip_p0   <= fpga_ip_i;
      host_ip_p0   <= host_ip_i;
      fpga_port_p0 <= fpga_port_i;
      host_port_p0 <= host_port_i;
    end
    if (state_p0 == PREAMBLE) begin
      csum_p1 <= ip_csum(tot_len, fpga_ip_p0, host_ip_p0);
    end
`ifdef UDP_GMII_FCS_EN
    if (start) begin
      crc_p1 <= '1;
    end else if (state_p0 inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, PAD}) begin
      crc_p1 <= crc32_byte(crc_p1, byte_n);
    end
`endif
  end

endmodule

// File: tb/tb_udp_gmii_frame_tx.sv
// Directed testbench for udp_gmii_frame_tx (honours UDP_GMII_FCS_EN).
module tb_udp_gmii_frame_tx;

`ifdef UDP_GMII_FCS_EN
  localparam int FCS_LEN = 4;
`else
  localparam int FCS_LEN = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [10:0] payload_bytes_i;
  logic [47:0] fpga_mac_i, host_mac_i;
  logic [31:0] fpga_ip_i, host_ip_i;
  logic [15:0] fpga_port_i, host_port_i;
  logic        tx_en_o;
  logic [7:0]  tx_d_o;
  logic        underrun_o;

  udp_gmii_frame_tx dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tready   (s_axis_tready),
    .payload_bytes_i (payload_bytes_i),
    .fpga_mac_i      (fpga_mac_i),
    .host_mac_i      (host_mac_i),
    .fpga_ip_i       (fpga_ip_i),
    .host_ip_i       (host_ip_i),
    .fpga_port_i     (fpga_port_i),
    .host_port_i     (host_port_i),
    .tx_en_o         (tx_en_o),
    .tx_d_o          (tx_d_o),
    .underrun_o      (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [7:0] src_q[$];
  bit         last_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];

  bit drv_v, drv_r, prev_en, frame_done;
  int idle_run, gap_last, ur_cnt, rdy_cnt, beats, stall_at, stall_left;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: account for the handshake at the last posedge, sample the
  // outputs, then drive the stream for the next posedge.
  task automatic step();
    @(negedge clk_i);
    if (drv_v && drv_r && src_q.size() > 0) begin
      void'(src_q.pop_front());
      void'(last_q.pop_front());
      beats++;
    end
    if (tx_en_o) begin
      if (!prev_en) begin
        cap_q.delete();
        gap_last = idle_run;
        ur_cnt   = 0;
        rdy_cnt  = 0;
      end
      cap_q.push_back(tx_d_o);
      idle_run = 0;
    end else begin
      idle_run++;
    end
    if (underrun_o)    ur_cnt++;
    if (s_axis_tready) rdy_cnt++;
    frame_done = prev_en && !tx_en_o;
    prev_en    = tx_en_o;
    drv_r      = s_axis_tready;
    if (stall_left > 0) begin
      s_axis_tvalid = 1'b0;
      stall_left--;
    end else if (stall_at >= 0 && beats == stall_at) begin
      s_axis_tvalid = 1'b0;
      stall_left    = 2;
      stall_at      = -1;
    end else if (src_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
    end else begin
      s_axis_tvalid = 1'b0;
    end
    s_axis_tdata = (src_q.size() > 0) ? src_q[0] : 8'h00;
    s_axis_tlast = (src_q.size() > 0) ? last_q[0] : 1'b0;
    drv_v        = s_axis_tvalid;
  endtask

  task automatic run_frame(input string tag, input int limit);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < limit) begin
      step();
      n++;
      if (frame_done) done = 1'b1;
    end
    chk({tag, " frame completed"}, 64'(done), 64'd1);
  endtask

  task automatic flush_src();
    src_q.delete();
    last_q.delete();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drv_v         = 1'b0;
  endtask

  task automatic load_packet(input int len, input int last_idx, input int seed);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b = 8'((i * 7 + seed) & 255);
      src_q.push_back(b);
      last_q.push_back(i == last_idx);
    end
  endtask

  task automatic push_be(input logic [47:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
  endtask

  function automatic logic [15:0] ref_csum(input int n);
    int s;
    s = 'h4500 + (28 + n) + 'h4011 + int'(fpga_ip_i[31:16]) + int'(fpga_ip_i[15:0]) +
        int'(host_ip_i[31:16]) + int'(host_ip_i[15:0]);
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    return ~16'(s);
  endfunction

  function automatic logic [31:0] ref_crc(input int from, input int upto);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int k = from; k < upto; k++) begin
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ exp_q[k][j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  // Expected on-wire frame for payload length n, payload bytes from pay_q.
  task automatic build_exp(input int n);
    logic [31:0] crc;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    push_be(host_mac_i, 6);
    push_be(fpga_mac_i, 6);
    push_be(48'h0800, 2);
    push_be(48'h4500, 2);
    push_be(48'(28 + n), 2);
    push_be(48'h0, 2);
    push_be(48'h0, 2);
    push_be(48'h4011, 2);
    push_be(48'(ref_csum(n)), 2);
    push_be(48'(fpga_ip_i), 4);
    push_be(48'(host_ip_i), 4);
    push_be(48'(fpga_port_i), 2);
    push_be(48'(host_port_i), 2);
    push_be(48'(8 + n), 2);
    push_be(48'h0, 2);
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    for (int i = n; i < 18; i++) exp_q.push_back(8'h00);
    crc = ref_crc(8, exp_q.size());
    if (FCS_LEN == 4) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);
    end
  endtask

  task automatic cmp_frame(input string tag);
    int bad;
    bad = -1;
    chk({tag, " length vs model"}, 64'(cap_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (bad < 0 && (i >= cap_q.size() || cap_q[i] !== exp_q[i])) bad = i;
    end
    chk({tag, " first differing byte index"}, 64'(bad), 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  function automatic logic [15:0] w16(input int i);
    return {cap_q[i], cap_q[i+1]};
  endfunction

  function automatic logic [63:0] w64(input int i);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) v = {v[55:0], cap_q[i+k]};
    return v;
  endfunction

  initial begin
    int zc;
    int n;
    rstn_i          = 1'b0;
    s_axis_tdata    = 8'h00;
    s_axis_tvalid   = 1'b0;
    s_axis_tlast    = 1'b0;
    payload_bytes_i = 11'd0;
    fpga_mac_i      = 48'he86a64e7e830;
    host_mac_i      = 48'he86a64e7e829;
    fpga_ip_i       = 32'h0A0000F0;
    host_ip_i       = 32'h0A00000A;
    fpga_port_i     = 16'd17767;
    host_port_i     = 16'd17767;
    drv_v = 0; drv_r = 0; prev_en = 0; frame_done = 0;
    idle_run = 0; gap_last = 0; ur_cnt = 0; rdy_cnt = 0;
    beats = 0; stall_at = -1; stall_left = 0;

    // Reset state
    repeat (4) step();
    chk("reset tx_en_o", 64'(tx_en_o), 64'd0);
    chk("reset tx_d_o", 64'(tx_d_o), 64'd0);
    chk("reset s_axis_tready", 64'(s_axis_tready), 64'd0);
    chk("reset underrun_o", 64'(underrun_o), 64'd0);
    rstn_i = 1'b1;
    repeat (3) step();

    // Nominal 340-byte frame
    payload_bytes_i = 11'd340;
    load_packet(340, 339, 3);
    pay_q = src_q;
    run_frame("nominal", 1000);
    chk("nominal tx_en cycles", 64'(cap_q.size()), (FCS_LEN == 4) ? 64'd394 : 64'd390);
    chk("nominal preamble", w64(0), 64'h55555555555555D5);
    chk("nominal dst mac", {16'h0, w16(8), w16(10), w16(12)}, 64'he86a64e7e829);
    chk("nominal ethertype", 64'(w16(20)), 64'h0800);
    chk("nominal ip total_len", 64'(w16(24)), 64'h0170);
    chk("nominal ip checksum", 64'(w16(32)), 64'h6484);
    chk("nominal udp length", 64'(w16(46)), 64'h015C);
    chk("nominal underrun pulses", 64'(ur_cnt), 64'd0);
    chk("nominal tready cycles", 64'(rdy_cnt), 64'd340);
    build_exp(340);
    cmp_frame("nominal");
    repeat (15) step();

    // Minimum frame: one payload byte, 17 pad bytes
    payload_bytes_i = 11'd1;
    load_packet(1, 0, 90);
    pay_q = src_q;
    run_frame("minimum", 200);
    chk("minimum tx_en cycles", 64'(cap_q.size()), (FCS_LEN == 4) ? 64'd72 : 64'd68);
    zc = 0;
    for (int i = 51; i < 68; i++) if (cap_q[i] === 8'h00) zc++;
    chk("minimum pad zero bytes", 64'(zc), 64'd17);
    build_exp(1);
    cmp_frame("minimum");
    repeat (15) step();

    // Back-to-back packets
    payload_bytes_i = 11'd20;
    load_packet(20, 19, 17);
    pay_q = src_q;
    load_packet(20, 19, 101);
    run_frame("b2b first", 300);
    build_exp(20);
    cmp_frame("b2b first");
    pay_q.delete();
    for (int i = 0; i < 20; i++) pay_q.push_back(8'((i * 7 + 101) & 255));
    run_frame("b2b second", 300);
    chk("b2b idle gap", 64'(gap_last), 64'd12);
    chk("b2b second preamble", w64(0), 64'h55555555555555D5);
    build_exp(20);
    cmp_frame("b2b second");
    repeat (15) step();

    // Underrun: tvalid low for 3 cycles after 10 accepted beats
    payload_bytes_i = 11'd40;
    beats = 0;
    stall_at = 10;
    load_packet(40, 39, 55);
    pay_q.delete();
    for (int i = 0; i < 10; i++) pay_q.push_back(src_q[i]);
    repeat (3) pay_q.push_back(8'h00);
    for (int i = 10; i < 37; i++) pay_q.push_back(src_q[i]);
    run_frame("underrun", 300);
    flush_src();
    chk("underrun pulses", 64'(ur_cnt), 64'd3);
    chk("underrun tx_en cycles", 64'(cap_q.size()), 64'(90 + FCS_LEN));
    build_exp(40);
    cmp_frame("underrun");
    repeat (15) step();

    // Early tlast: N=64, packet ends at byte 10
    payload_bytes_i = 11'd64;
    load_packet(10, 9, 200);
    pay_q = src_q;
    repeat (54) pay_q.push_back(8'h00);
    run_frame("early tlast", 300);
    chk("early tlast tready cycles", 64'(rdy_cnt), 64'd10);
    zc = 0;
    for (int i = 60; i < 114; i++) if (cap_q[i] === 8'h00) zc++;
    chk("early tlast zero fill", 64'(zc), 64'd54);
    build_exp(64);
    cmp_frame("early tlast");
    repeat (15) step();

    // Reset during IP header, then a fresh frame
    payload_bytes_i = 11'd30;
    load_packet(30, 29, 9);
    n = 0;
    while (!(prev_en && cap_q.size() == 25) && n < 100) begin
      step();
      n++;
    end
    chk("mid-frame reached IP header", 64'(cap_q.size()), 64'd25);
    rstn_i = 1'b0;
    flush_src();
    step();
    chk("mid-frame reset tx_en_o", 64'(tx_en_o), 64'd0);
    chk("mid-frame reset tx_d_o", 64'(tx_d_o), 64'd0);
    chk("mid-frame reset tready", 64'(s_axis_tready), 64'd0);
    repeat (2) step();
    rstn_i = 1'b1;
    step();
    payload_bytes_i = 11'd5;
    load_packet(5, 4, 77);
    pay_q = src_q;
    run_frame("after reset", 200);
    chk("after reset preamble", w64(0), 64'h55555555555555D5);
    build_exp(5);
    cmp_frame("after reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/udp_gmii_frame_tx.md
Name: udp_gmii_frame_tx

Overview:
- Turns an 8-bit AXI-Stream payload into a complete Ethernet II / IPv4 / UDP frame on a GMII transmit interface (tx_en/txd).
- Sits between user logic and the RGMII/GMII PHY adapter.
- Addresses, ports and payload length are static sideband inputs, sampled once at frame start.

Parameters:
- GMII_WIDTH, 8, GMII data width; only 8 is supported.
- PAYLOAD_WIDTH, 11, width of payload_bytes_i.
- AXIS_DATA_WIDTH, 8, s_axis_tdata width; only 8 is supported.
- IFG_CYCLES, 12, minimum idle cycles after each frame.

Ports:
- clk_i  in  1  GMII TX clock; the only clock.
- rstn_i  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  AXIS_DATA_WIDTH  payload byte.
- s_axis_tvalid  in  1  payload valid.
- s_axis_tlast  in  1  last payload byte of packet.
- s_axis_tready  out  1  payload accepted.
- payload_bytes_i  in  PAYLOAD_WIDTH  UDP payload length in bytes.
- fpga_mac_i  in  48  source MAC.
- host_mac_i  in  48  destination MAC.
- fpga_ip_i  in  32  source IPv4 address.
- host_ip_i  in  32  destination IPv4 address.
- fpga_port_i  in  16  UDP source port.
- host_port_i  in  16  UDP destination port.
- tx_en_o  out  1  GMII transmit enable.
- tx_d_o  out  GMII_WIDTH  GMII transmit data.
- underrun_o  out  1  one-cycle pulse for each payload byte substituted.

Behaviour:
- Reset values: tx_en_o=0, tx_d_o=0, s_axis_tready=0, underrun_o=0. FSM returns to IDLE; any partial frame is abandoned immediately.

- FSM states: IDLE -> PREAMBLE -> ETH_HDR -> IP_HDR -> UDP_HDR -> PAYLOAD -> PAD -> FCS -> IFG -> IDLE.
- Frame start (IDLE): s_axis_tvalid=1 and payload_bytes_i!=0.
  - All sideband inputs are latched on the start cycle.
  - payload_bytes_i values above 1472 are clamped to 1472.
  - tx_en_o rises on the next cycle; all outputs are registered.
  - While in IDLE, s_axis_tready=0.
- PREAMBLE: 7 bytes of 0x55, then 0xD5.
- ETH_HDR: host_mac, then fpga_mac, MSB first; ethertype 0x0800.
- IP_HDR, in order: 0x45, 0x00, total_len=28+N, id 0x0000, flags/frag 0x0000, TTL 0x40, proto 0x11, header checksum, fpga_ip, host_ip.
  - Header checksum = one's complement of the end-around-carry sum of the ten 16-bit header words, with the checksum word taken as 0.
  - The checksum is computed during PREAMBLE.
- UDP_HDR: fpga_port, host_port, length=8+N, checksum 0x0000.
- PAYLOAD: exactly N bytes.
  - s_axis_tready=1 for exactly N cycles.
  - If tvalid=0, send 0x00 and pulse underrun_o.
  - If tlast arrives before byte N, tready drops and the remaining bytes are 0x00.
  - A packet longer than N is not terminated: its excess bytes start or feed the next frame.
- PAD: when 28+N<46, append 46-(28+N) bytes of 0x00.
- FCS: CRC-32 over the destination MAC through the last pad byte.
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement.
  - Sent least-significant byte first.
- IFG: tx_en_o=0 and tx_d_o=0 for IFG_CYCLES cycles; no new frame starts until IFG completes.
- tx_en_o is continuous across a frame, with no gaps.
- Inputs changing mid-frame have no effect.

Optional Feature:
- Macro: UDP_GMII_FCS_EN.
- Defined: the FCS state is present and the 4-byte CRC is appended, as above.
- Undefined: no CRC logic is built; PAD (or PAYLOAD) goes directly to IFG, and tx_en_o is high 4 fewer cycles per frame.

Test Plan:
- Nominal frame: N=340, fpga 10.0.0.240:17767 / e8:6a:64:e7:e8:30, host 10.0.0.10:17767 / e8:6a:64:e7:e8:29, 340-byte stream with tlast on the final byte.
  - tx_en_o high for 394 cycles (390 without FCS).
  - IP total_len 0x0170, UDP length 0x015C, IP checksum 0x6484.
  - Payload bytes match the stream; FCS matches the bench CRC model.
- Minimum frame: N=1 -> 17 pad bytes of 0x00; tx_en_o high for 72 cycles.
- Back-to-back: two packets presented continuously -> exactly 12 idle cycles between frames, second preamble intact.
- Underrun: tvalid held low for 3 cycles mid-payload -> 3 bytes of 0x00 sent, 3 underrun_o pulses, frame length unchanged.
- Early tlast: N=64 with tlast on byte 10 -> 54 bytes of 0x00 follow; tready=0 after byte 10.
- Reset mid-frame: rstn_i low during IP_HDR -> next cycle tx_en_o=0; after release the first tvalid starts a fresh preamble.
